// File: rtl/mem_access_sequencer.sv
// Multi-cycle ARM mode-2/mode-3 load/store sequencer: decodes the captured
// instruction, runs one or two req/ack beats and writes aligned load data back.
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         ir,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0] store_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rf_we,
  output logic                rf_sel,
  output logic [DATA_W-1:0]   rf_wdata
);

  localparam int NL = DATA_W / 8;
  localparam int LB = $clog2(NL);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_WB, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t                state;
  logic [31:0]           ir_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2*DATA_W-1:0]   sd_q;
  logic                  beat;
  logic [CW-1:0]         cnt;

  logic                  dec_legal;
  logic                  dec_load;
  logic                  dec_signed;
  logic                  dec_dbl;
  logic [1:0]            dec_size;
  logic                  misaligned;
  logic                  unused_ir_bits;

  assign unused_ir_bits = ^{ir_q[31:28], ir_q[24:23], ir_q[21], ir_q[19:8], ir_q[3:0]};

  always_comb begin
    dec_legal  = 1'b0;
    dec_load   = 1'b0;
    dec_signed = 1'b0;
    dec_dbl    = 1'b0;
    dec_size   = SZ_WORD;
    if (ir_q[27:26] == 2'b01) begin
      dec_legal = 1'b1;
      dec_load  = ir_q[20];
      dec_size  = ir_q[22] ? SZ_BYTE : SZ_WORD;
    end else if (ir_q[27:25] == 3'b000 && ir_q[7] && ir_q[4]) begin
      // Mode 3: L and SH jointly select the op; LDRD/STRD live in the L=0 half.
      case ({ir_q[20], ir_q[6:5]})
        3'b101: begin dec_legal = 1'b1; dec_load = 1'b1; dec_size = SZ_HALF; end
        3'b110: begin dec_legal = 1'b1; dec_load = 1'b1; dec_size = SZ_BYTE; dec_signed = 1'b1; end
        3'b111: begin dec_legal = 1'b1; dec_load = 1'b1; dec_size = SZ_HALF; dec_signed = 1'b1; end
        3'b001: begin dec_legal = 1'b1; dec_size = SZ_HALF; end
        3'b010: begin dec_legal = 1'b1; dec_load = 1'b1; dec_dbl = 1'b1; end
        3'b011: begin dec_legal = 1'b1; dec_dbl = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    if (dec_size == SZ_HALF)
      misaligned = addr_q[0];
    else if (dec_size == SZ_WORD)
      misaligned = (addr_q[LB-1:0] != '0);
  end

  function automatic logic [DATA_W-1:0] lanes(input logic [1:0] sz, input logic [DATA_W-1:0] v);
    case (sz)
      SZ_BYTE: return {NL{v[7:0]}};
      SZ_HALF: return {(NL/2){v[15:0]}};
      default: return {(DATA_W/32){v[31:0]}};
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [1:0] sz, input logic sgn,
                                                input logic [LB-1:0] o,
                                                input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] sh;
    sh = rd >> {o, 3'b000};
    case (sz)
      SZ_BYTE: return sgn ? DATA_W'($signed(sh[7:0]))  : DATA_W'(sh[7:0]);
      SZ_HALF: return sgn ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0]);
      default: return DATA_W'(rd[31:0]);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ir_q      <= '0;
      addr_q    <= '0;
      sd_q      <= '0;
      beat      <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_we     <= 1'b0;
      rf_sel    <= 1'b0;
      rf_wdata  <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ir_q   <= ir;
            addr_q <= addr;
            sd_q   <= store_data;
            busy   <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!dec_legal || misaligned) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_FAIL;
          end else begin
            beat      <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= ~dec_load;
            mem_size  <= dec_size;
            mem_addr  <= addr_q;
            mem_wdata <= lanes(dec_size, sd_q[DATA_W-1:0]);
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack in the last permitted wait cycle still completes the beat.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (dec_load) begin
              rf_we    <= 1'b1;
              rf_sel   <= beat;
              rf_wdata <= extract(dec_size, dec_signed, mem_addr[LB-1:0], mem_rdata);
              state    <= S_WB;
            end else begin
              state <= S_NEXT;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: state <= S_NEXT;
        S_NEXT: begin
          if (dec_dbl && !beat) begin
            beat      <= 1'b1;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(NL);
            mem_wdata <= lanes(SZ_WORD, sd_q[2*DATA_W-1:DATA_W]);
            state     <= S_REQ;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE, S_FAIL: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
